wb_write_queue: RTL and testbench

- Writeback-side write queue sitting directly upstream of the 32x32 register file write port.
- Accepts register writes from two producers, the ALU result path and the load-return path, buffers them in order in a small FIFO, and drains one write per cycle onto the register file write port (we3/A3/WD3).
- Provides a busy mask and two read-bypass lookup ports so that decode reads (RD1/RD2 addresses) can forward queued data not yet written.

---
 rtl/wb_write_queue.sv | 134 +++++++++++++
 tb/tb_wb_write_queue.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_write_queue.sv
// Writeback write queue: buffers load/ALU register writes in order and drains one per cycle to the regfile port.
// Optional stats counters (wr_total, stall_cycles) are built when WBQ_STATS_EN is defined.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ld_valid,
  input  logic [AW-1:0]              ld_rd,
  input  logic [DW-1:0]              ld_data,
  output logic                       ld_ready,
  input  logic                       alu_valid,
  input  logic [AW-1:0]              alu_rd,
  input  logic [DW-1:0]              alu_data,
  output logic                       alu_ready,
  input  logic                       wb_hold,
  output logic                       we3,
  output logic [AW-1:0]              A3,
  output logic [DW-1:0]              WD3,
  input  logic [AW-1:0]              q1_addr,
  input  logic [AW-1:0]              q2_addr,
  output logic                       q1_hit,
  output logic                       q2_hit,
  output logic [DW-1:0]              q1_data,
  output logic [DW-1:0]              q2_data,
  output logic [31:0]                busy_mask,
  output logic [$clog2(DEPTH):0]     count
`ifdef WBQ_STATS_EN
  ,
  output logic [31:0]                wr_total,
  output logic [31:0]                stall_cycles
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][AW-1:0] r_rd;
  logic [DEPTH-1:0][DW-1:0] r_data;
  logic [PW-1:0]            r_head, r_tail;
  logic [CW-1:0]            r_count;

  logic [CW-1:0] w_free;
  logic          w_enq_ld, w_enq_alu, w_deq;
  logic [PW-1:0] w_alu_slot;

  // Readiness looks only at registered occupancy; a same-cycle drain gives no credit.
  assign w_free    = CW'(DEPTH) - r_count;
  assign ld_ready  = (w_free != '0);
  assign alu_ready = (w_free >= CW'(2)) || ((w_free == CW'(1)) && !ld_valid);

  // Writes to r0 complete the handshake but never occupy a slot.
  assign w_enq_ld   = ld_valid  && ld_ready  && (ld_rd  != '0);
  assign w_enq_alu  = alu_valid && alu_ready && (alu_rd != '0);
  assign w_alu_slot = w_enq_ld ? r_tail + PW'(1) : r_tail;
  assign w_deq      = (r_count != '0) && !wb_hold;

  assign we3   = w_deq;
  assign A3    = r_rd[r_head];
  assign WD3   = r_data[r_head];
  assign count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_deq) r_vld[r_head] <= 1'b0;
      if (w_enq_ld) begin
        r_vld[r_tail]  <= 1'b1;
        r_rd[r_tail]   <= ld_rd;
        r_data[r_tail] <= ld_data;
      end
      if (w_enq_alu) begin
        r_vld[w_alu_slot]  <= 1'b1;
        r_rd[w_alu_slot]   <= alu_rd;
        r_data[w_alu_slot] <= alu_data;
      end
      r_head  <= r_head + PW'(w_deq);
      r_tail  <= r_tail + PW'(w_enq_ld) + PW'(w_enq_alu);
      r_count <= r_count + CW'(w_enq_ld) + CW'(w_enq_alu) - CW'(w_deq);
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    logic [PW-1:0] w_idx;
    q1_hit  = 1'b0;
    q2_hit  = 1'b0;
    q1_data = '0;
    q2_data = '0;
    w_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (r_vld[w_idx] && (r_rd[w_idx] == q1_addr) && (q1_addr != '0)) begin
        q1_hit  = 1'b1;
        q1_data = r_data[w_idx];
      end
      if (r_vld[w_idx] && (r_rd[w_idx] == q2_addr) && (q2_addr != '0)) begin
        q2_hit  = 1'b1;
        q2_data = r_data[w_idx];
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int b = 1; b < 32; b++)
        if (r_vld[i] && (32'(r_rd[i]) == 32'(b))) busy_mask[b] = 1'b1;
  end

`ifdef WBQ_STATS_EN
  logic [31:0] r_wr_total, r_stall_cycles;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_total     <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_wr_total     <= r_wr_total + 32'(we3);
      r_stall_cycles <= r_stall_cycles +
                        32'((ld_valid && !ld_ready) || (alu_valid && !alu_ready));
    end
  end
  assign wr_total     = r_wr_total;
  assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// Directed bench for wb_write_queue: a scoreboard holds expected regfile writes, a negedge monitor pops them.
module tb_wb_write_queue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid, alu_valid, wb_hold;
  logic [4:0]  ld_rd, alu_rd, q1_addr, q2_addr;
  logic [31:0] ld_data, alu_data;
  logic        ld_ready, alu_ready, we3, q1_hit, q2_hit;
  logic [4:0]  A3;
  logic [31:0] WD3, q1_data, q2_data, busy_mask;
  logic [2:0]  count;

  typedef struct packed { logic [4:0] rd; logic [31:0] d; } wr_t;
  wr_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .wb_hold(wb_hold), .we3(we3), .A3(A3), .WD3(WD3),
    .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_data(q1_data), .q2_data(q2_data), .busy_mask(busy_mask), .count(count)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] rd, input logic [31:0] d);
    wr_t e;
    e.rd = rd;
    e.d  = d;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && we3 === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wb_unexpected: got A3=%0d WD3=0x%0h expected no write", A3, WD3);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wb_A3", 64'(A3), 64'(e.rd));
        chk("wb_WD3", 64'(WD3), 64'(e.d));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ld_valid = 0; alu_valid = 0; wb_hold = 0;
    ld_rd = 0; alu_rd = 0; ld_data = 0; alu_data = 0; q1_addr = 0; q2_addr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we3", 64'(we3), 0);
    chk("rst_count", 64'(count), 0);
    chk("rst_busy", 64'(busy_mask), 0);
    chk("rst_A3", 64'(A3), 0);
    chk("rst_WD3", 64'(WD3), 0);
    chk("rst_ld_ready", 64'(ld_ready), 1);
    chk("rst_alu_ready", 64'(alu_ready), 1);
    cyc(); rst_n = 1'b1;

    // single ALU write
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; push(5, 32'hDEADBEEF);
    @(negedge clk); chk("t1_alu_ready", 64'(alu_ready), 1);
    cyc(); alu_valid = 0;
    @(negedge clk); chk("t1_we3", 64'(we3), 1); chk("t1_count1", 64'(count), 1);
    cyc();
    @(negedge clk); chk("t1_we3_off", 64'(we3), 0); chk("t1_count0", 64'(count), 0);

    // same-cycle load+ALU to the same rd
    cyc();
    wb_hold = 1; q1_addr = 3; q2_addr = 7;
    ld_valid = 1; ld_rd = 3; ld_data = 32'h11; push(3, 32'h11);
    alu_valid = 1; alu_rd = 3; alu_data = 32'h22; push(3, 32'h22);
    @(negedge clk);
    chk("t2_ld_ready", 64'(ld_ready), 1);
    chk("t2_alu_ready", 64'(alu_ready), 1);
    chk("t2_hit_not_yet", 64'(q1_hit), 0);
    cyc(); ld_valid = 0; alu_valid = 0;
    @(negedge clk);
    chk("t2_count2", 64'(count), 2);
    chk("t2_q1_hit", 64'(q1_hit), 1);
    chk("t2_q1_data", 64'(q1_data), 32'h22);
    chk("t2_q2_hit", 64'(q2_hit), 0);
    chk("t2_busy", 64'(busy_mask), 32'h8);
    chk("t2_held", 64'(we3), 0);
    cyc(); wb_hold = 0;
    @(negedge clk);
    chk("t2_we3", 64'(we3), 1);
    chk("t2_head_visible", 64'(q1_data), 32'h22);
    cyc();
    @(negedge clk);
    chk("t2_count1", 64'(count), 1);
    chk("t2_busy1", 64'(busy_mask), 32'h8);
    chk("t2_q1_data1", 64'(q1_data), 32'h22);
    cyc();
    @(negedge clk);
    chk("t2_count0", 64'(count), 0);
    chk("t2_busy0", 64'(busy_mask), 0);
    chk("t2_hit0", 64'(q1_hit), 0);

    // write to r0 is dropped
    cyc();
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF;
    @(negedge clk); chk("t3_alu_ready", 64'(alu_ready), 1);
    cyc(); alu_valid = 0;
    @(negedge clk); chk("t3_count", 64'(count), 0); chk("t3_we3", 64'(we3), 0);

    // fill under hold, load priority at count=3, then release
    cyc(); wb_hold = 1;
    for (int i = 1; i <= 3; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h100 + 32'(i);
      push(5'(i), 32'h100 + 32'(i));
      cyc();
    end
    ld_valid = 1; ld_rd = 4; ld_data = 32'h104;
    alu_rd = 9; alu_data = 32'h999;
    @(negedge clk);
    chk("t4_count3", 64'(count), 3);
    chk("t4_ld_ready", 64'(ld_ready), 1);
    chk("t4_alu_ready", 64'(alu_ready), 0);
    push(4, 32'h104);
    cyc(); ld_valid = 0;
    @(negedge clk);
    chk("t4_count4", 64'(count), 4);
    chk("t4_ld_ready_full", 64'(ld_ready), 0);
    chk("t4_alu_ready_full", 64'(alu_ready), 0);
    chk("t4_busy", 64'(busy_mask), 32'h1E);
    cyc();
    @(negedge clk);
    chk("t4_count_stable", 64'(count), 4);
    chk("t4_alu_stalled", 64'(alu_ready), 0);
    cyc(); wb_hold = 0;
    @(negedge clk);
    chk("t4_we3_rel", 64'(we3), 1);
    chk("t4_no_credit", 64'(alu_ready), 0);
    cyc();
    @(negedge clk);
    chk("t4_ready_rise", 64'(alu_ready), 1);
    chk("t4_we3_2", 64'(we3), 1);
    push(9, 32'h999);
    cyc(); alu_valid = 0;
    @(negedge clk); chk("t4_count_after", 64'(count), 3);
    repeat (4) cyc();
    @(negedge clk); chk("t4_drained", 64'(count), 0);

    // async reset with 3 queued entries
    cyc(); wb_hold = 1; q1_addr = 12;
    for (int i = 11; i <= 13; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h200 + 32'(i);
      cyc();
    end
    alu_valid = 0;
    @(negedge clk);
    chk("t6_count3", 64'(count), 3);
    chk("t6_busy", 64'(busy_mask), 32'h3800);
    chk("t6_hit", 64'(q1_hit), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_count", 64'(count), 0);
    chk("t6_rst_busy", 64'(busy_mask), 0);
    chk("t6_rst_we3", 64'(we3), 0);
    chk("t6_rst_hit", 64'(q1_hit), 0);
    @(posedge clk); #1 rst_n = 1'b1; wb_hold = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("t6_no_stale", 64'(we3), 0);
    end
    chk("t6_count_final", 64'(count), 0);
    chk("sb_empty", 64'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
